// File: rtl/axi_ro_pkg.sv
// Shared definitions for the ring-oscillator counter bank: register map,
// CTRL/STATUS bit positions, measurement FSM states and a byte-strobe helper.
package axi_ro_pkg;

  // Byte offsets of the register map
  localparam int ADDR_CTRL    = 'h00;
  localparam int ADDR_STATUS  = 'h04;
  localparam int ADDR_WINDOW  = 'h08;
  localparam int ADDR_CH_MASK = 'h0C;
  localparam int ADDR_COUNT0  = 'h10;

  // Largest channel count whose COUNT registers fit the 6-bit address space
  localparam int MAX_CH = 12;

  // CTRL bits
  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int CTRL_CONT  = 2;

  // STATUS bits
  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_DONE    = 1;
  localparam int STATUS_OVF_LSB = 16;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_GATE,
    ST_LATCH
  } state_t;

  // Merge new_v into old_v byte by byte where the write strobe is set
  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ro_gated_counter.sv
// One measurement channel: counts RO edges while gated, saturates at the
// counter maximum with a sticky overflow flag, and latches the result.
module ro_gated_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 arm,
  input  logic                 gate_en,
  input  logic                 pulse,
  input  logic                 latch,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 ovf
);

  logic [CNT_WIDTH-1:0] work;

  // Working counter, latched result and sticky overflow; clear beats everything
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      work  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (arm) begin
        work <= '0;
      end else if (gate_en && pulse) begin
        if (work == '1) ovf  <= 1'b1;
        else            work <= work + 1'b1;
      end
      if (latch) count <= work;
    end
  end

endmodule

// File: rtl/axi_ro_counter_bank.sv
// AXI4-Lite controlled bank of gated ring-oscillator edge counters with
// single-shot / continuous measurement, per-channel mask and overflow flags.
module axi_ro_counter_bank
  import axi_ro_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_CH             = 4,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_CH-1:0]               ro_en,
  input  logic [NUM_CH-1:0]               ro_pulse
);

  state_t               state;
  logic                 cont;
  logic                 done;
  logic [31:0]          window;
  logic [31:0]          gate_cnt;
  logic [NUM_CH-1:0]    ch_mask;
  logic [NUM_CH-1:0]    ovf;
  logic [CNT_WIDTH-1:0] count [NUM_CH];

  logic        wr_fire;
  logic [31:0] wr_idx;
  logic [31:0] rd_idx;
  logic [31:0] ctrl_word;
  logic [31:0] status_word;
  logic [31:0] rd_val;
  logic [2:0]  ctrl_new;
  logic        start_req;
  logic        clear_req;

  // Word indices; the low address bits fall away in the shift
  assign wr_idx  = 32'(S_AXI_AWADDR) >> 2;
  assign rd_idx  = 32'(S_AXI_ARADDR) >> 2;
  assign wr_fire = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;

  // START/CLEAR are stored as 0, so a strobe-merged CTRL write only pulses them when byte 0 is written
  assign ctrl_word = 32'(cont) << CTRL_CONT;
  assign ctrl_new  = 3'(apply_strb(ctrl_word, S_AXI_WDATA, S_AXI_WSTRB));
  assign clear_req = wr_fire && (wr_idx == ADDR_CTRL / 4) && ctrl_new[CTRL_CLEAR];
  assign start_req = wr_fire && (wr_idx == ADDR_CTRL / 4) && ctrl_new[CTRL_START] && !ctrl_new[CTRL_CLEAR];

  // Write address/data handshake and write response
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
    end else begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      if (S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !S_AXI_AWREADY) begin
        S_AXI_AWREADY <= 1'b1;
        S_AXI_WREADY  <= 1'b1;
      end
      if (wr_fire) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= RESP_OKAY;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  // Writable configuration registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cont    <= 1'b0;
      window  <= 32'd1;
      ch_mask <= '0;
    end else if (wr_fire) begin
      case (wr_idx)
        ADDR_CTRL / 4:    cont    <= ctrl_new[CTRL_CONT];
        ADDR_WINDOW / 4:  window  <= apply_strb(window, S_AXI_WDATA, S_AXI_WSTRB);
        ADDR_CH_MASK / 4: ch_mask <= NUM_CH'(apply_strb(32'(ch_mask), S_AXI_WDATA, S_AXI_WSTRB));
        default: ;
      endcase
    end
  end

  // Measurement sequencer: ARM -> GATE (window cycles) -> LATCH, looping while CONT
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= ST_IDLE;
      done     <= 1'b0;
      gate_cnt <= '0;
      ro_en    <= '0;
    end else if (clear_req) begin
      state <= ST_IDLE;
      done  <= 1'b0;
      ro_en <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            done  <= 1'b0;
            state <= ST_ARM;
          end
        end
        ST_ARM: begin
          done     <= 1'b0;
          gate_cnt <= (window == '0) ? 32'd1 : window;
          ro_en    <= ch_mask;
          state    <= ST_GATE;
        end
        ST_GATE: begin
          gate_cnt <= gate_cnt - 32'd1;
          if (gate_cnt <= 32'd1) state <= ST_LATCH;
        end
        ST_LATCH: begin
          done  <= 1'b1;
          ro_en <= '0;
          state <= cont ? ST_ARM : ST_IDLE;
        end
      endcase
    end
  end

  // Channels count only while gated and enabled by the mask captured at ARM
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ro_gated_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk    (ACLK),
      .rst    (ARESET),
      .clear  (clear_req),
      .arm    (state == ST_ARM),
      .gate_en((state == ST_GATE) && ro_en[g]),
      .pulse  (ro_pulse[g]),
      .latch  (state == ST_LATCH),
      .count  (count[g]),
      .ovf    (ovf[g])
    );
  end

  // STATUS word assembly and read-data mux
  always_comb begin
    status_word = '0;
    status_word[STATUS_BUSY] = (state != ST_IDLE);
    status_word[STATUS_DONE] = done;
    status_word[STATUS_OVF_LSB +: MAX_CH] = MAX_CH'(ovf);

    rd_val = '0;
    case (rd_idx)
      ADDR_CTRL / 4:    rd_val = ctrl_word;
      ADDR_STATUS / 4:  rd_val = status_word;
      ADDR_WINDOW / 4:  rd_val = window;
      ADDR_CH_MASK / 4: rd_val = 32'(ch_mask);
      default: begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (rd_idx == ADDR_COUNT0 / 4 + i) rd_val = 32'(count[i]);
        end
      end
    endcase
  end

  // Read address handshake and read data channel
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      S_AXI_ARREADY <= 1'b0;
      if (S_AXI_ARVALID && !S_AXI_RVALID && !S_AXI_ARREADY) S_AXI_ARREADY <= 1'b1;
      if (S_AXI_ARREADY && S_AXI_ARVALID) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_val;
        S_AXI_RRESP  <= RESP_OKAY;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_ro_counter_bank.sv
// Directed bench for axi_ro_counter_bank (4 channels, 8-bit counters).
module tb_axi_ro_counter_bank;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int SENTINEL = 1 << 30;

  logic        aclk = 1'b0;
  logic        areset;
  logic [5:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [5:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [NCH-1:0] ro_en;
  logic [NCH-1:0] ro_pulse;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wr_edge_cyc = SENTINEL;
  int pulse_mode = 0;
  int c0;
  logic [31:0] rd_d;
  logic [1:0]  rd_r;

  axi_ro_counter_bank #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .NUM_CH            (NCH),
    .CNT_WIDTH         (CW)
  ) dut (
    .ACLK         (aclk),
    .ARESET       (areset),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .ro_en        (ro_en),
    .ro_pulse     (ro_pulse)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Mode 1: channel i pulses on every (i+2)-th gate cycle counted from the START edge
  always @(negedge aclk) begin
    int d;
    d = cyc - wr_edge_cyc;
    case (pulse_mode)
      1: for (int i = 0; i < NCH; i++) ro_pulse[i] = (d >= 1) && ((d % (i + 2)) == 0);
      2: ro_pulse = 4'b1001;
      default: ro_pulse = '0;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    if (cyc > target) check("schedule", cyc, target);
    while (cyc < target) begin
      @(posedge aclk); #1;
    end
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_lead, input int b_hold);
    int n;
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    awvalid = 1'b1;
    bready  = (b_hold == 0);
    for (int k = 0; k < aw_lead; k++) begin
      @(posedge aclk); #1;
      check("awready_before_w", awready, 1'b0);
    end
    wvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin
      @(posedge aclk); #1;
      n++;
    end
    if (n >= 20) check("aw_timeout", awready, 1'b1);
    check("wready_with_awready", wready, awready);
    @(posedge aclk); #1;
    wr_edge_cyc = cyc;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("bvalid_rise", bvalid, 1'b1);
    for (int k = 0; k < b_hold; k++) begin
      @(posedge aclk); #1;
      check("bvalid_hold", bvalid, 1'b1);
    end
    if (b_hold > 0) check("bresp", bresp, 2'b00);
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    araddr  = addr;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(posedge aclk); #1;
      n++;
    end
    if (n >= 20) check("ar_timeout", arready, 1'b1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin
      @(posedge aclk); #1;
      n++;
    end
    if (n >= 20) check("r_timeout", rvalid, 1'b1);
    data = rdata;
    resp = rresp;
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, d, r);
    check(tag, d, exp);
  endtask

  initial begin
    areset  = 1'b1;
    awaddr  = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr  = '0; arvalid = 1'b0; rready = 1'b0;
    ro_pulse = '0;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_handshake", {awready, wready, bvalid, arready, rvalid}, 5'b0);
    check("rst_ro_en", ro_en, 4'h0);
    areset = 1'b0;
    @(posedge aclk); #1;
    rd_chk("rst_ctrl",   6'h00, 32'h0);
    rd_chk("rst_status", 6'h04, 32'h0);
    rd_chk("rst_window", 6'h08, 32'h1);
    rd_chk("rst_mask",   6'h0C, 32'h0);

    // Single shot, WINDOW=100, channel i pulses every (i+2) cycles
    axi_write(6'h08, 32'd100, 4'hF, 0, 0);
    axi_write(6'h0C, 32'hF, 4'hF, 0, 0);
    wr_edge_cyc = SENTINEL;
    pulse_mode  = 1;
    axi_write(6'h00, 32'h1, 4'hF, 0, 0);
    c0 = wr_edge_cyc;
    wait_cyc(c0 + 1);
    check("m1_ro_en_arm", ro_en, 4'hF);
    rd_chk("m1_status_busy", 6'h04, 32'h1);
    wait_cyc(c0 + 101);
    check("m1_ro_en_gate_end", ro_en, 4'hF);
    wait_cyc(c0 + 102);
    check("m1_ro_en_latch", ro_en, 4'h0);
    pulse_mode = 0;
    rd_chk("m1_status_done", 6'h04, 32'h2);
    rd_chk("m1_count0", 6'h10, 32'd50);
    rd_chk("m1_count1", 6'h14, 32'd33);
    rd_chk("m1_count2", 6'h18, 32'd25);
    rd_chk("m1_count3", 6'h1C, 32'd20);

    // Saturation: ch0 and masked ch3 pulse every cycle for 400 cycles
    axi_write(6'h08, 32'd400, 4'hF, 0, 0);
    axi_write(6'h0C, 32'h7, 4'hF, 0, 0);
    pulse_mode = 2;
    axi_write(6'h00, 32'h1, 4'hF, 0, 0);
    c0 = wr_edge_cyc;
    wait_cyc(c0 + 401);
    check("sat_ro_en_gate", ro_en, 4'h7);
    wait_cyc(c0 + 402);
    check("sat_ro_en_latch", ro_en, 4'h0);
    pulse_mode = 0;
    rd_chk("sat_status", 6'h04, 32'h0001_0002);
    rd_chk("sat_count0", 6'h10, 32'd255);
    rd_chk("sat_count1", 6'h14, 32'd0);
    rd_chk("sat_count3_masked", 6'h1C, 32'd0);

    // CLEAR in the middle of a gate window
    axi_write(6'h08, 32'd50, 4'hF, 0, 0);
    axi_write(6'h0C, 32'hF, 4'hF, 0, 0);
    wr_edge_cyc = SENTINEL;
    pulse_mode  = 1;
    axi_write(6'h00, 32'h1, 4'hF, 0, 0);
    c0 = wr_edge_cyc;
    wait_cyc(c0 + 10);
    check("clr_ro_en_gate", ro_en, 4'hF);
    axi_write(6'h00, 32'h2, 4'hF, 0, 0);
    check("clr_ro_en", ro_en, 4'h0);
    rd_chk("clr_status", 6'h04, 32'h0);
    rd_chk("clr_count0", 6'h10, 32'h0);
    wait_cyc(c0 + 60);
    check("clr_ro_en_late", ro_en, 4'h0);
    rd_chk("clr_count0_late", 6'h10, 32'h0);
    pulse_mode = 0;

    // Continuous mode, WINDOW=10: period of WINDOW+2 cycles
    axi_write(6'h08, 32'd10, 4'hF, 0, 0);
    axi_write(6'h00, 32'h5, 4'hF, 0, 0);
    c0 = wr_edge_cyc;
    wait_cyc(c0 + 11);
    check("cont_w1_gate", ro_en, 4'hF);
    wait_cyc(c0 + 12);
    check("cont_w1_latch", ro_en, 4'h0);
    wait_cyc(c0 + 13);
    check("cont_w2_arm", ro_en, 4'hF);
    wait_cyc(c0 + 24);
    check("cont_w2_latch", ro_en, 4'h0);
    wait_cyc(c0 + 25);
    check("cont_w3_arm", ro_en, 4'hF);
    wait_cyc(c0 + 26);
    axi_write(6'h00, 32'h0, 4'hF, 0, 0);
    wait_cyc(c0 + 35);
    check("cont_w3_gate", ro_en, 4'hF);
    wait_cyc(c0 + 36);
    check("cont_w3_latch", ro_en, 4'h0);
    wait_cyc(c0 + 38);
    check("cont_no_rearm", ro_en, 4'h0);
    rd_chk("cont_status", 6'h04, 32'h2);
    rd_chk("cont_ctrl", 6'h00, 32'h0);

    // WINDOW=0 behaves as a one-cycle gate
    axi_write(6'h08, 32'd0, 4'hF, 0, 0);
    rd_chk("win0_readback", 6'h08, 32'h0);
    axi_write(6'h00, 32'h1, 4'hF, 0, 0);
    c0 = wr_edge_cyc;
    wait_cyc(c0 + 2);
    check("win0_gate", ro_en, 4'hF);
    wait_cyc(c0 + 3);
    check("win0_latch", ro_en, 4'h0);
    rd_chk("win0_status", 6'h04, 32'h2);

    // AXI stress: AW leads W, BREADY held off, byte strobe on WINDOW
    axi_write(6'h08, 32'h1234_5678, 4'hF, 0, 0);
    axi_write(6'h08, 32'hAABB_CCDD, 4'h1, 3, 5);
    rd_chk("strb_window", 6'h08, 32'h1234_56DD);
    axi_write(6'h0C, 32'hFFFF_FFFF, 4'hF, 0, 0);
    rd_chk("mask_upper_zero", 6'h0C, 32'hF);
    axi_write(6'h04, 32'hFFFF_FFFF, 4'hF, 0, 0);
    rd_chk("status_ro", 6'h04, 32'h2);
    axi_read(6'h3C, rd_d, rd_r);
    check("unmapped_data", rd_d, 32'h0);
    check("unmapped_resp", rd_r, 2'b00);
    rd_chk("unmapped_count4", 6'h20, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
